kernel_ram_tester: RTL and testbench
====================================

// Module: kernel_ram_tester
// PURPOSE
//  Avalon-MM master that drives the s1 port of the kernel on-chip RAM. On start it fills
//  words 0..DEPTH-1 with a seeded pattern, reads every word back and compares it.
//  Reports pass/fail, the error count and the first failing address.
//  Sits beside the Nios II core as a bring-up/self-test engine. No waitrequest; read latency is 1.
// PARAMETERS
//  ADDR_W   11   word address width (DEPTH = 2**ADDR_W = 2048)
//  DATA_W   32   data width; byteenable width is DATA_W/8
//  ERR_W    16   error counter width; the counter saturates
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       synchronous reset, active low
//  start           in   1       1-cycle pulse; accepted only in IDLE
//  pause           in   1       freeze request; deasserts clken while high
//  mode            in   1       pattern select, sampled at start
//  seed            in   DATA_W  pattern seed, sampled at start
//  busy            out  1       high from the cycle after start until DONE
//  done            out  1       1-cycle pulse when the test completes
//  pass            out  1       valid while done is high or in IDLE after a test; 1 = no errors
//  err_count       out  ERR_W   mismatches in the last test, saturating
//  first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none
//  address         out  ADDR_W  Avalon word address
//  byteenable      out  DATA_W/8  always all ones
//  chipselect      out  1       Avalon chipselect
//  write           out  1       Avalon write
//  writedata       out  DATA_W  Avalon write data
//  readdata        in   DATA_W  Avalon read data, valid 1 clken-cycle after the read address
//  clken           out  1       RAM clock enable = ~pause
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state IDLE.
//   - busy, done, pass, chipselect and write are 0.
//   - err_count, first_err_addr, address and writedata are 0.
//   - byteenable is all ones.
//   - Reset mid-test aborts immediately. No further bus cycles are issued; RAM contents are undefined.
//  Pattern: P(a) = seed_q + a (mod 2**DATA_W) when mode_q=0; P(a) = ~(seed_q + a) when mode_q=1.
//  FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
//   - IDLE: on start, latch seed and mode, clear err_count and first_err_addr, set addr=0, go to WRITE.
//   - WRITE: each advancing cycle drives chipselect=1, write=1, address=addr, writedata=P(addr), then addr++.
//     After addr=DEPTH-1 is written: addr=0, go to READ. No wrap beyond DEPTH-1.
//   - READ: each advancing cycle drives chipselect=1, write=0, address=addr.
//     The expected value P(addr) is registered alongside. The compare for address a-1 happens in the cycle
//     that address a is issued. After addr=DEPTH-1 is issued, go to DRAIN.
//   - DRAIN: chipselect=0; compare the final word (DEPTH-1); go to DONE.
//   - DONE: done=1 for 1 cycle, busy=0, pass=(err_count==0); go to IDLE.
//  Compare: a mismatch is readdata != expected. On a mismatch err_count++ unless it is all ones (saturate).
//   first_err_addr is captured only on the first mismatch of the test.
//  pause=1: clken=0, the FSM, addr and the compare pipeline hold, and bus outputs hold their values.
//   No compare occurs during a paused cycle. Because readdata is held by the RAM, the compare resumes
//   correctly after pause falls.
//  start while busy: ignored. start with pause=1 in IDLE: accepted; the first bus cycle waits for pause=0.
//  start and reset_n=0 in the same cycle: reset wins.
//  Latency with pause=0: start to done = 2*DEPTH + 3 cycles (4099 at the defaults). busy is high for
//   2*DEPTH+2 cycles.
//  Widths: the pattern add wraps modulo 2**DATA_W. addr is ADDR_W+1 bits internally so the terminal
//   count is unambiguous.
// TESTING
//  1. Reset, then start with seed=0, mode=0, against the RAM model.
//     -> Word 5 reads 0x5; done after 4099 cycles; pass=1; err_count=0.
//  2. mode=1, seed=0xFFFFFFF0. -> Word 0x10 holds ~0x0 = 0xFFFFFFFF (wrap); pass=1.
//  3. Force RAM word 0x123 to stuck-at 0xDEADBEEF during READ.
//     -> err_count=1, first_err_addr=0x123, pass=0.
//  4. Toggle pause for 3 cycles at random points, and pulse start while busy.
//     -> The second start is ignored. The result matches test 1; start to done = 4099 + paused cycles.
//  5. Pulse reset_n low mid-WRITE, then start again.
//     -> All outputs are 0 the cycle after reset; the second run passes.
//  6. Model with every read corrupted and ERR_W=4. -> err_count saturates at 0xF, first_err_addr=0.

Source files
------------

// File: rtl/kernel_ram_tester.sv
// kernel_ram_tester: Avalon-MM bring-up master for the kernel on-chip RAM.
// Fills every word with a seeded pattern, reads it back, and reports errors.
module kernel_ram_tester #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                pause,
  input  logic                mode,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  input  logic [DATA_W-1:0]   readdata,
  output logic                clken
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     addr_reg, addr_next;
  logic [ADDR_W:0]     addr_inc;
  logic                drain_last_reg, drain_last_next;
  logic [DATA_W-1:0]   seed_reg, seed_next;
  logic                mode_reg, mode_next;
  logic                tested_reg, tested_next;

  logic [ADDR_W-1:0]   address_reg, address_next;
  logic                chipselect_reg, chipselect_next;
  logic                write_reg, write_next;
  logic [DATA_W-1:0]   writedata_reg, writedata_next;
  logic [DATA_W-1:0]   exp_issue_reg, exp_issue_next;

  logic                cmp_valid_reg, cmp_valid_next;
  logic [DATA_W-1:0]   exp_cmp_reg, exp_cmp_next;
  logic [ADDR_W-1:0]   addr_cmp_reg, addr_cmp_next;
  logic [ERR_W-1:0]    err_count_reg, err_count_next;
  logic [ADDR_W-1:0]   first_err_reg, first_err_next;

  logic                advance;
  logic                mismatch;
  logic [DATA_W-1:0]   pattern_now;

  function automatic logic [DATA_W-1:0] pattern_of(input logic [DATA_W-1:0] s,
                                                   input logic m,
                                                   input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] sum;
    sum = s + DATA_W'(a);
    return m ? ~sum : sum;
  endfunction

  assign advance     = ~pause;
  assign addr_inc    = addr_reg + (ADDR_W+1)'(1);
  assign pattern_now = pattern_of(seed_reg, mode_reg, addr_reg[ADDR_W-1:0]);
  // readdata belongs to the read issued on the bus one clken-cycle earlier
  assign mismatch    = cmp_valid_reg && (readdata != exp_cmp_reg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      drain_last_reg <= 1'b0;
      seed_reg       <= '0;
      mode_reg       <= 1'b0;
      tested_reg     <= 1'b0;
      address_reg    <= '0;
      chipselect_reg <= 1'b0;
      write_reg      <= 1'b0;
      writedata_reg  <= '0;
      exp_issue_reg  <= '0;
      cmp_valid_reg  <= 1'b0;
      exp_cmp_reg    <= '0;
      addr_cmp_reg   <= '0;
      err_count_reg  <= '0;
      first_err_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      drain_last_reg <= drain_last_next;
      seed_reg       <= seed_next;
      mode_reg       <= mode_next;
      tested_reg     <= tested_next;
      address_reg    <= address_next;
      chipselect_reg <= chipselect_next;
      write_reg      <= write_next;
      writedata_reg  <= writedata_next;
      exp_issue_reg  <= exp_issue_next;
      cmp_valid_reg  <= cmp_valid_next;
      exp_cmp_reg    <= exp_cmp_next;
      addr_cmp_reg   <= addr_cmp_next;
      err_count_reg  <= err_count_next;
      first_err_reg  <= first_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    drain_last_next = drain_last_reg;
    seed_next       = seed_reg;
    mode_next       = mode_reg;
    tested_next     = tested_reg;
    address_next    = address_reg;
    chipselect_next = chipselect_reg;
    write_next      = write_reg;
    writedata_next  = writedata_reg;
    exp_issue_next  = exp_issue_reg;
    cmp_valid_next  = cmp_valid_reg;
    exp_cmp_next    = exp_cmp_reg;
    addr_cmp_next   = addr_cmp_reg;
    err_count_next  = err_count_reg;
    first_err_next  = first_err_reg;

    // Compare pipeline: bus read -> data returned -> checked, frozen while paused
    if (advance) begin
      cmp_valid_next = chipselect_reg & ~write_reg;
      exp_cmp_next   = exp_issue_reg;
      addr_cmp_next  = address_reg;
      if (mismatch) begin
        if (~&err_count_reg) begin
          err_count_next = err_count_reg + ERR_W'(1);
        end
        if (err_count_reg == '0) begin
          first_err_next = addr_cmp_reg;
        end
      end
    end

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          seed_next      = seed;
          mode_next      = mode;
          err_count_next = '0;
          first_err_next = '0;
          tested_next    = 1'b0;
          addr_next      = '0;
          state_next     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (advance) begin
          chipselect_next = 1'b1;
          write_next      = 1'b1;
          address_next    = addr_reg[ADDR_W-1:0];
          writedata_next  = pattern_now;
          if (addr_inc[ADDR_W]) begin
            addr_next  = '0;
            state_next = S_READ;
          end else begin
            addr_next = addr_inc;
          end
        end
      end
      S_READ: begin
        if (advance) begin
          chipselect_next = 1'b1;
          write_next      = 1'b0;
          address_next    = addr_reg[ADDR_W-1:0];
          exp_issue_next  = pattern_now;
          if (addr_inc[ADDR_W]) begin
            addr_next       = '0;
            drain_last_next = 1'b0;
            state_next      = S_DRAIN;
          end else begin
            addr_next = addr_inc;
          end
        end
      end
      S_DRAIN: begin
        // Two cycles: one for the last read to return, one to compare it
        if (advance) begin
          chipselect_next = 1'b0;
          write_next      = 1'b0;
          if (drain_last_reg) begin
            state_next = S_DONE;
          end else begin
            drain_last_next = 1'b1;
          end
        end
      end
      S_DONE: begin
        tested_next = 1'b1;
        state_next  = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
      assign byteenable[gi] = 1'b1;
    end
  endgenerate

  assign busy           = (state_reg == S_WRITE) || (state_reg == S_READ) || (state_reg == S_DRAIN);
  assign done           = (state_reg == S_DONE);
  assign pass           = (err_count_reg == '0) &&
                          ((state_reg == S_DONE) || ((state_reg == S_IDLE) && tested_reg));
  assign err_count      = err_count_reg;
  assign first_err_addr = first_err_reg;
  assign address        = address_reg;
  assign chipselect     = chipselect_reg;
  assign write          = write_reg;
  assign writedata      = writedata_reg;
  assign clken          = ~pause;

endmodule

// File: tb/tb_kernel_ram_tester.sv
// Testbench for kernel_ram_tester: RAM models with fault injection and a
// formula-based reference for pattern, error count, first error and latency.
module tb_kernel_ram_tester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, pause, mode;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [10:0] first_err_addr, address;
  logic [3:0]  byteenable;
  logic        chipselect, write;
  logic [31:0] writedata, readdata;
  logic        clken;
  logic        stuck_en;
  logic [31:0] mem [0:2047];

  logic        start2, pause2, mode2;
  logic [31:0] seed2;
  logic        busy2, done2, pass2;
  logic [3:0]  err_count2;
  logic [4:0]  first_err_addr2, address2;
  logic [3:0]  byteenable2;
  logic        chipselect2, write2;
  logic [31:0] writedata2, readdata2;
  logic        clken2;
  logic [31:0] mem2 [0:31];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kernel_ram_tester dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(readdata), .clken(clken)
  );

  kernel_ram_tester #(.ADDR_W(5), .DATA_W(32), .ERR_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .pause(pause2), .mode(mode2), .seed(seed2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .first_err_addr(first_err_addr2),
    .address(address2), .byteenable(byteenable2), .chipselect(chipselect2), .write(write2),
    .writedata(writedata2), .readdata(readdata2), .clken(clken2)
  );

  // On-chip RAM model, latency 1, with an optional stuck read at word 0x123
  always @(posedge clk) begin
    if (clken) begin
      if (chipselect && write) mem[address] <= writedata;
      if (chipselect && !write)
        readdata <= (stuck_en && address == 11'h123) ? 32'hDEADBEEF : mem[address];
    end
  end

  // Small RAM whose every read returns corrupted data
  always @(posedge clk) begin
    if (clken2) begin
      if (chipselect2 && write2) mem2[address2] <= writedata2;
      if (chipselect2 && !write2) readdata2 <= ~mem2[address2];
    end
  end

  function automatic logic [31:0] pat(input logic [31:0] s, input logic m, input int a);
    logic [31:0] v;
    v = s + 32'(a);
    return m ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run1(input logic [31:0] s, input logic m, input bit with_pause, input bit extra_start,
                      output int edges, output int busy_cyc, output int paused);
    int  w0, w1, w2;
    bit  got;
    w0 = $urandom_range(1300, 5);
    w1 = $urandom_range(2700, 1400);
    w2 = $urandom_range(4000, 2800);
    seed = s; mode = m; start = 1'b1;
    edges = 0; busy_cyc = 0; paused = 0; got = 1'b0;
    while (!got && edges < 6000) begin
      @(posedge clk); #1;
      edges++;
      start = extra_start && (edges == 100);
      if (busy) busy_cyc++;
      if (done) begin
        got = 1'b1;
      end else begin
        pause = with_pause && ((edges >= w0 && edges < w0 + 3) || (edges >= w1 && edges < w1 + 3) ||
                               (edges >= w2 && edges < w2 + 3));
        if (pause) paused++;
      end
    end
    pause = 1'b0;
    start = 1'b0;
    $display("run seed=%08h mode=%0d edges=%0d busy=%0d paused=%0d err=%0d first=%0h pass=%0d",
             s, m, edges, busy_cyc, paused, err_count, first_err_addr, pass);
  endtask

  function automatic int mem_bad(input logic [31:0] s, input logic m);
    int bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== pat(s, m, i)) bad++;
    return bad;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int edges, busy_cyc, paused, exp_err, rw;
    logic [31:0] s;
    logic        m;

    reset_n = 1'b0; start = 1'b0; pause = 1'b0; mode = 1'b0; seed = '0; stuck_en = 1'b0;
    start2 = 1'b0; pause2 = 1'b0; mode2 = 1'b0; seed2 = '0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cs", chipselect, 0);
    check("rst_wr", write, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_addr, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", writedata, 0);
    check("rst_be", byteenable, 4'hF);
    start = 1'b1;
    step();
    check("reset_wins_over_start", busy, 0);
    start = 1'b0;
    reset_n = 1'b1;
    step();

    // Test 1: seed 0, mode 0
    run1(32'h0, 1'b0, 1'b0, 1'b0, edges, busy_cyc, paused);
    check("t1_latency", edges, 4099);
    check("t1_busy_cycles", busy_cyc, 4098);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_first", first_err_addr, 0);
    check("t1_word5", mem[5], 32'h5);
    check("t1_mem_all_bad", mem_bad(32'h0, 1'b0), 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_pass_idle", pass, 1);

    // Test 2: inverted pattern with wrap
    run1(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, edges, busy_cyc, paused);
    check("t2_latency", edges, 4099);
    check("t2_word16", mem[16], 32'hFFFF_FFFF);
    check("t2_mem_all_bad", mem_bad(32'hFFFF_FFF0, 1'b1), 0);
    check("t2_pass", pass, 1);
    step();

    // Test 3: stuck word during read back
    s = $urandom; m = 1'($urandom);
    stuck_en = 1'b1;
    run1(s, m, 1'b0, 1'b0, edges, busy_cyc, paused);
    exp_err = (pat(s, m, 'h123) != 32'hDEADBEEF) ? 1 : 0;
    check("t3_err", err_count, exp_err);
    check("t3_first", first_err_addr, exp_err ? 11'h123 : 11'h0);
    check("t3_pass", pass, exp_err == 0);
    stuck_en = 1'b0;
    step();
    check("t3_pass_idle", pass, exp_err == 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t3_rst_err", err_count, 0);
    check("t3_rst_first", first_err_addr, 0);
    check("t3_rst_pass", pass, 0);
    step();

    // Test 4: pauses and an ignored second start
    s = $urandom; m = 1'($urandom);
    run1(s, m, 1'b1, 1'b1, edges, busy_cyc, paused);
    check("t4_latency", edges, 4099 + paused);
    check("t4_busy_cycles", busy_cyc, 4098 + paused);
    check("t4_pass", pass, 1);
    check("t4_err", err_count, 0);
    check("t4_mem_all_bad", mem_bad(s, m), 0);
    step();
    pause = 1'b1; #1;
    check("t4_clken_paused", clken, 0);
    pause = 1'b0; #1;
    check("t4_clken_run", clken, 1);

    // Test 5: reset mid-WRITE, then a clean rerun
    seed = $urandom; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (500) step();
    check("t5_mid_write", {chipselect, write}, 2'b11);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cs", chipselect, 0);
    check("t5_rst_wr", write, 0);
    check("t5_rst_addr", address, 0);
    check("t5_rst_wdata", writedata, 0);
    check("t5_rst_done_pass", {done, pass}, 2'b00);
    step();
    s = $urandom; m = 1'($urandom);
    run1(s, m, 1'b0, 1'b0, edges, busy_cyc, paused);
    check("t5_latency", edges, 4099);
    check("t5_pass", pass, 1);
    check("t5_mem_all_bad", mem_bad(s, m), 0);
    step();

    // Test 6: small RAM, every read corrupted, 4-bit saturating counter
    seed2 = $urandom; mode2 = 1'($urandom); start2 = 1'b1;
    edges = 0;
    while (!done2 && edges < 500) begin
      step();
      edges++;
      start2 = 1'b0;
    end
    $display("run2 seed=%08h mode=%0d edges=%0d err=%0d first=%0h pass=%0d",
             seed2, mode2, edges, err_count2, first_err_addr2, pass2);
    check("t6_latency", edges, 2 * 32 + 3);
    check("t6_err_sat", err_count2, 4'hF);
    check("t6_first", first_err_addr2, 0);
    check("t6_pass", pass2, 0);
    rw = $urandom_range(31, 0);
    check("t6_mem_word", mem2[rw], pat(seed2, mode2, rw));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
